pixel_sequencer: RTL and testbench
==================================

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 Parameter PIXEL_BITS, default 8, width of DIGITAL_RAMP and of the convert ramp length (2^PIXEL_BITS cycles).
REQ-002 Parameter NUM_ROWS, default 2, number of pixel rows read out per frame.
REQ-003 Parameter C_ERASE, default 5, ERASE duration in CLK cycles (>=1).
REQ-004 Parameter C_READ, default 5, READ duration per row in CLK cycles (>=1).
REQ-005 CLK  input  1  single system clock; all logic on rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 START  input  1  request one frame; sampled only in IDLE.
REQ-008 ABORT  input  1  terminate current frame; sampled in every state.
REQ-009 EXPOSE_CYCLES  input  16  exposure duration; latched on accepted START.
REQ-010 ERASE  output  1  pixel erase strobe, high for the whole ERASE state.
REQ-011 EXPOSE  output  1  pixel expose strobe, high for the whole EXPOSE state.
REQ-012 CONVERT  output  1  analog ramp enable, high for the whole CONVERT state.
REQ-013 DIGITAL_RAMP  output  PIXEL_BITS  digital ramp code shared with all pixel rows.
REQ-014 READ  output  1  row read enable, high during READ state.
REQ-015 ROW_SEL  output  clog2(NUM_ROWS) (min 1)  index of row being read.
REQ-016 BUSY  output  1  high in every state except IDLE.
REQ-017 FRAME_DONE  output  1  one-cycle pulse on completion of last row's READ.

Function
REQ-018 All outputs SHALL be registered; states IDLE, ERASE, EXPOSE, CONVERT, READ; exactly one of ERASE/EXPOSE/CONVERT/READ high outside IDLE, none in IDLE.
REQ-019 IDLE: START=1 and ABORT=0 at edge N -> ERASE=1 and BUSY=1 from edge N+1; EXPOSE_CYCLES latched at edge N.
REQ-020 ERASE SHALL last exactly C_ERASE cycles, then EXPOSE.
REQ-021 EXPOSE SHALL last exactly latched EXPOSE_CYCLES cycles; latched value 0 treated as 1.
REQ-022 CONVERT SHALL last exactly 2^PIXEL_BITS cycles; DIGITAL_RAMP = 0 in first CONVERT cycle, +1 each cycle, reaches all-ones in last cycle, no wrap.
REQ-023 DIGITAL_RAMP SHALL be 0 in every state other than CONVERT.
REQ-024 READ: ROW_SEL starts at 0, each row held C_READ cycles, ROW_SEL increments between rows with READ continuously high; total NUM_ROWS*C_READ cycles.
REQ-025 After last row: FRAME_DONE=1 for one cycle coincident with return to IDLE (BUSY=0 same cycle).
REQ-026 ROW_SEL SHALL be 0 outside READ.
REQ-027 START while BUSY SHALL be ignored (not queued); EXPOSE_CYCLES changes while BUSY have no effect.
REQ-028 ABORT=1 at any edge while BUSY -> IDLE next cycle, all strobes 0, DIGITAL_RAMP 0, no FRAME_DONE; ABORT has priority over START in IDLE.
REQ-029 Internal duration counter SHALL be wide enough for max(16-bit exposure, 2^PIXEL_BITS, C_ERASE, C_READ) without overflow.

Reset
REQ-030 RESET=1 at an edge -> next cycle: state IDLE, ERASE/EXPOSE/CONVERT/READ/BUSY/FRAME_DONE=0, DIGITAL_RAMP=0, ROW_SEL=0, counters and latched exposure 0.
REQ-031 RESET SHALL override START and ABORT and take effect from any state, including mid-CONVERT and mid-READ.

Configuration
REQ-032 Macro PIXEL_SEQ_CONTINUOUS_EN: when defined, after FRAME_DONE the block SHALL enter ERASE directly (no IDLE cycle, BUSY stays 1) re-latching EXPOSE_CYCLES in the FRAME_DONE cycle, until ABORT or RESET; when undefined, IDLE is entered and a new START is required.

Verification
REQ-033 Defaults, EXPOSE_CYCLES=10, START 1 cycle -> ERASE 5, EXPOSE 10, CONVERT 256 (ramp 0..255), READ 10 (ROW_SEL 0 x5, 1 x5), FRAME_DONE 1 cycle at cycle 282 after START edge.
REQ-034 EXPOSE_CYCLES=0 -> EXPOSE high exactly 1 cycle; EXPOSE_CYCLES changed to 50 during EXPOSE -> duration unchanged.
REQ-035 ABORT at CONVERT with DIGITAL_RAMP=100 -> next cycle IDLE, CONVERT=0, DIGITAL_RAMP=0, no FRAME_DONE; subsequent START runs full frame.
REQ-036 RESET asserted in READ with ROW_SEL=1 -> next cycle all outputs 0; START held during RESET ignored.
REQ-037 START pulsed repeatedly during a frame -> exactly one FRAME_DONE; START and ABORT together in IDLE -> stays IDLE.
REQ-038 With PIXEL_SEQ_CONTINUOUS_EN: FRAME_DONE cycle followed immediately by ERASE=1, BUSY never drops across 3 frames; ABORT ends sequence.

Source files
------------

// File: rtl/pixel_sequencer.sv
// pixel_sequencer: erase/expose/convert/read frame sequencer for a pixel array.
// Define PIXEL_SEQ_CONTINUOUS_EN to chain frames back-to-back until ABORT or RESET.
module pixel_sequencer #(
  parameter int PIXEL_BITS = 8,
  parameter int NUM_ROWS   = 2,
  parameter int C_ERASE    = 5,
  parameter int C_READ     = 5
) (
  input  logic                                            CLK,
  input  logic                                            RESET,
  input  logic                                            START,
  input  logic                                            ABORT,
  input  logic [15:0]                                     EXPOSE_CYCLES,
  output logic                                            ERASE,
  output logic                                            EXPOSE,
  output logic                                            CONVERT,
  output logic [PIXEL_BITS-1:0]                           DIGITAL_RAMP,
  output logic                                            READ,
  output logic [(NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1)-1:0] ROW_SEL,
  output logic                                            BUSY,
  output logic                                            FRAME_DONE
);
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int RW = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
  localparam int CW = max2(max2(16, PIXEL_BITS), max2($clog2(C_ERASE), $clog2(C_READ)));
  // One-hot encoding lets the strobe outputs come straight from state flops.
  typedef enum logic [3:0] {
    S_IDLE    = 4'b0000,
    S_ERASE   = 4'b0001,
    S_EXPOSE  = 4'b0010,
    S_CONVERT = 4'b0100,
    S_READ    = 4'b1000
  } state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RW-1:0]         row_q, row_d;
  logic [15:0]           exp_q, exp_d, exp_last;
  logic [PIXEL_BITS-1:0] ramp_q, ramp_d;
  logic                  busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    row_d    = row_q;
    exp_d    = exp_q;
    done_d   = 1'b0;
    exp_last = exp_q == 16'd0 ? 16'd0 : exp_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (START && !ABORT) begin
          state_d = S_ERASE;
          exp_d   = EXPOSE_CYCLES;
        end
      end
      S_ERASE: if (cnt_q == CW'(C_ERASE - 1)) begin
        state_d = S_EXPOSE;
        cnt_d   = '0;
      end
      S_EXPOSE: if (cnt_q == CW'(exp_last)) begin
        state_d = S_CONVERT;
        cnt_d   = '0;
      end
      S_CONVERT: if (cnt_q == CW'(2 ** PIXEL_BITS - 1)) begin
        state_d = S_READ;
        cnt_d   = '0;
      end
      S_READ: if (cnt_q == CW'(C_READ - 1)) begin
        cnt_d = '0;
        row_d = row_q + RW'(1);
        if (row_q == RW'(NUM_ROWS - 1)) begin
          row_d  = '0;
          done_d = 1'b1;
`ifdef PIXEL_SEQ_CONTINUOUS_EN
          state_d = S_ERASE;
          exp_d   = EXPOSE_CYCLES;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (ABORT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      row_d   = '0;
      done_d  = 1'b0;
    end
    ramp_d = state_d == S_CONVERT ? cnt_d[PIXEL_BITS-1:0] : '0;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      exp_q   <= '0;
      ramp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      exp_q   <= exp_d;
      ramp_q  <= ramp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign ERASE        = state_q[0];
  assign EXPOSE       = state_q[1];
  assign CONVERT      = state_q[2];
  assign READ         = state_q[3];
  assign ROW_SEL      = row_q;
  assign DIGITAL_RAMP = ramp_q;
  assign BUSY         = busy_q;
  assign FRAME_DONE   = done_q;
endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer: directed frame-level checks of pixel_sequencer at default parameters.
module tb_pixel_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] exp_cyc = 16'd0;
  logic        erase, expose, convert, read, busy, done;
  logic [7:0]  ramp;
  logic [0:0]  row_sel;
  int n_tests = 0, n_fail = 0;
  int n_er, n_ex, n_cv, n_rd, n_r1, n_done, first_done, bad, n_idle, ramp_last, post_done_bad;

  pixel_sequencer dut (
    .CLK(clk), .RESET(rst), .START(start), .ABORT(abort), .EXPOSE_CYCLES(exp_cyc),
    .ERASE(erase), .EXPOSE(expose), .CONVERT(convert), .DIGITAL_RAMP(ramp),
    .READ(read), .ROW_SEL(row_sel), .BUSY(busy), .FRAME_DONE(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] e);
    exp_cyc = e;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  // Samples cycles 1..max (cycle 1 = current one) and accumulates per-frame statistics.
  task automatic run(input int max, input bit spam, input bit chg);
    bit prev_done = 1'b0;
    n_er = 0; n_ex = 0; n_cv = 0; n_rd = 0; n_r1 = 0; n_done = 0;
    first_done = 0; bad = 0; n_idle = 0; ramp_last = -1; post_done_bad = 0;
    for (int k = 1; k <= max; k++) begin
      if (k > 1) step();
      if (prev_done && !erase) post_done_bad++;
      prev_done = done;
      if (erase) n_er++;
      if (expose) n_ex++;
      if (read) n_rd++;
      if (read && row_sel == 1'b1) n_r1++;
      if (!read && row_sel != 1'b0) bad++;
      if (convert) begin
        if (int'(ramp) != n_cv) bad++;
        n_cv++;
        ramp_last = int'(ramp);
      end else if (ramp != 8'd0) bad++;
      if (int'(erase) + int'(expose) + int'(convert) + int'(read) != int'(busy)) bad++;
      if (!busy) n_idle++;
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = k;
`ifndef PIXEL_SEQ_CONTINUOUS_EN
        if (busy) bad++;
`endif
      end
      if (spam) start = (n_done == 0) ? ~start : 1'b0;
      if (chg && expose) exp_cyc = 16'd50;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_erase"}, erase, 0);
    check({tag, "_expose"}, expose, 0);
    check({tag, "_convert"}, convert, 0);
    check({tag, "_read"}, read, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ramp"}, ramp, 0);
    check({tag, "_row"}, row_sel, 0);
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    check_quiet("reset");
    step();
    check_quiet("idle");
`ifdef PIXEL_SEQ_CONTINUOUS_EN
    go(16'd10);
    run(3 * 281 + 10, 1'b0, 1'b0);
    check("cont_done", n_done, 3);
    check("cont_idle", n_idle, 0);
    check("cont_erase_after_done", post_done_bad, 0);
    check("cont_bad", bad, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_quiet("cont_abort");
    step();
    check("cont_abort_stay", busy, 0);
`else
    go(16'd10);
    run(285, 1'b0, 1'b0);
    check("f_erase", n_er, 5);
    check("f_expose", n_ex, 10);
    check("f_convert", n_cv, 256);
    check("f_read", n_rd, 10);
    check("f_row1", n_r1, 5);
    check("f_done_cyc", first_done, 282);
    check("f_done_n", n_done, 1);
    check("f_ramp_last", ramp_last, 255);
    check("f_bad", bad, 0);

    go(16'd0);
    run(275, 1'b0, 1'b0);
    check("e0_expose", n_ex, 1);
    check("e0_done_cyc", first_done, 273);
    check("e0_bad", bad, 0);

    go(16'd20);
    run(295, 1'b0, 1'b1);
    check("chg_expose", n_ex, 20);
    check("chg_done_cyc", first_done, 292);

    go(16'd10);
    run(116, 1'b0, 1'b0);
    check("ab_pre_convert", convert, 1);
    check("ab_pre_ramp", ramp, 100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_quiet("ab_post");
    run(20, 1'b0, 1'b0);
    check("ab_no_done", n_done, 0);
    check("ab_idle", n_idle, 20);
    go(16'd10);
    run(285, 1'b0, 1'b0);
    check("ab_next_done_cyc", first_done, 282);
    check("ab_next_convert", n_cv, 256);

    go(16'd10);
    run(277, 1'b0, 1'b0);
    check("rs_pre_read", read, 1);
    check("rs_pre_row", row_sel, 1);
    rst = 1'b1;
    start = 1'b1;
    step();
    check_quiet("rs_post");
    step();
    check("rs_held_busy", busy, 0);
    rst = 1'b0;
    start = 1'b0;
    step();
    check("rs_after_busy", busy, 0);

    exp_cyc = 16'd10;
    start = 1'b1;
    step();
    run(400, 1'b1, 1'b0);
    start = 1'b0;
    check("spam_done_n", n_done, 1);
    check("spam_erase", n_er, 5);
    check("spam_done_cyc", first_done, 282);

    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_erase", erase, 0);
    step();
    check("sa_busy2", busy, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
